// File: rtl/gate_driver_protect_unit_pkg.sv
// Shared types, default parameter values and the request decoder
// for the gate-drive protection unit.
package gate_driver_protect_unit_pkg;

    // Per-phase conduction state
    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } phase_state_e;

    // Decoded per-phase request
    typedef enum logic [1:0] {
        ReqOff  = 2'd0,
        ReqHigh = 2'd1,
        ReqLow  = 2'd2
    } phase_req_e;

    localparam int unsigned DefaultDeadtimeCycles    = 50;
    localparam int unsigned DefaultFaultFilterCycles = 4;

    // Both sides requested at once is treated as "off"; the caller flags the error.
    function automatic phase_req_e decode_req(input logic high, input logic low);
        phase_req_e req;
        case ({high, low})
            2'b10:   req = ReqHigh;
            2'b01:   req = ReqLow;
            default: req = ReqOff;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/gate_phase_deadtime.sv
// Single half-bridge phase: request decode, OFF/HIGH/LOW FSM with dead-time
// counter, registered gate outputs and shoot-through error pulse.
module gate_phase_deadtime
    import gate_driver_protect_unit_pkg::*;
#(
    parameter int unsigned DEADTIME_CYCLES = DefaultDeadtimeCycles
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic force_off_i,
    input  logic high_req_i,
    input  logic low_req_i,
    output logic high_o,
    output logic low_o,
    output logic shoot_err_o
);

    localparam int unsigned CntW = (DEADTIME_CYCLES == 0) ? 1 : $clog2(DEADTIME_CYCLES + 1);
    localparam logic [CntW-1:0] DeadLoad = CntW'(DEADTIME_CYCLES);

    phase_state_e    state_q, state_d;
    logic [CntW-1:0] dead_cnt_q, dead_cnt_d;
    logic            high_q, high_d;
    logic            low_q, low_d;
    logic            err_q, err_d;
    phase_req_e      req;

    // Next-state logic: force-off wins, then HIGH/LOW exit on any other request,
    // OFF waits out the dead counter before accepting a new request.
    always_comb begin
        req        = decode_req(high_req_i, low_req_i);
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        err_d      = high_req_i & low_req_i;
        if (force_off_i) begin
            // Reloading every forced cycle makes the full dead time apply on release.
            state_d    = StOff;
            dead_cnt_d = DeadLoad;
        end else begin
            unique case (state_q)
                StHigh: begin
                    if (req != ReqHigh) begin
                        state_d    = StOff;
                        dead_cnt_d = DeadLoad;
                    end
                end
                StLow: begin
                    if (req != ReqLow) begin
                        state_d    = StOff;
                        dead_cnt_d = DeadLoad;
                    end
                end
                StOff: begin
                    if (dead_cnt_q != '0) begin
                        dead_cnt_d = dead_cnt_q - 1'b1;
                    end else if (req == ReqHigh) begin
                        state_d = StHigh;
                    end else if (req == ReqLow) begin
                        state_d = StLow;
                    end
                end
                default: begin
                    state_d    = StOff;
                    dead_cnt_d = DeadLoad;
                end
            endcase
        end
        high_d = (state_d == StHigh);
        low_d  = (state_d == StLow);
    end

    // State, counter and output registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StOff;
            dead_cnt_q <= '0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            high_q     <= high_d;
            low_q      <= low_d;
            err_q      <= err_d;
        end
    end

    assign high_o      = high_q;
    assign low_o       = low_q;
    assign shoot_err_o = err_q;

endmodule

// File: rtl/gate_driver_protect_unit.sv
// Fault-protected gate-drive output stage: nFAULT synchroniser, glitch
// filter and fault latch, plus one dead-time phase per half-bridge.
module gate_driver_protect_unit
    import gate_driver_protect_unit_pkg::*;
#(
    parameter int unsigned PHASE_NUM           = 3,
    parameter int unsigned DEADTIME_CYCLES     = DefaultDeadtimeCycles,
    parameter int unsigned FAULT_FILTER_CYCLES = DefaultFaultFilterCycles,
    parameter int unsigned FAULT_LATCH         = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 gate_driver_nfault_in,
    input  logic                 gate_enable_in,
    input  logic                 fault_clear_in,
    input  logic [PHASE_NUM-1:0] gate_high_side_in,
    input  logic [PHASE_NUM-1:0] gate_low_side_in,
    output logic [PHASE_NUM-1:0] gate_high_side_out,
    output logic [PHASE_NUM-1:0] gate_low_side_out,
    output logic                 fault_latched_out,
    output logic [PHASE_NUM-1:0] shoot_through_err_out
);

    localparam int unsigned FiltW = $clog2(FAULT_FILTER_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltMax = FiltW'(FAULT_FILTER_CYCLES);

    logic             sync1_q, sync2_q;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fault_q, fault_d;
    logic             fault_det;
    logic             force_off;

    // Filter counter and fault latch next state. fault_det is taken from the
    // counter's next value so the latch and the phase outputs react on the
    // same edge the counter saturates.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        if (sync2_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q != FiltMax) begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fault_det = (filt_cnt_d == FiltMax);
        if (FAULT_LATCH != 0) begin
            // A clear only takes effect once the filtered fault has gone away.
            fault_d = fault_det | (fault_q & ~fault_clear_in);
        end else begin
            fault_d = fault_det;
        end
        force_off = ~gate_enable_in | fault_det | fault_q;
    end

    // Synchroniser, filter and latch registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            filt_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            sync1_q    <= gate_driver_nfault_in;
            sync2_q    <= sync1_q;
            filt_cnt_q <= filt_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign fault_latched_out = fault_q;

    for (genvar i = 0; i < PHASE_NUM; i++) begin : g_phase
        gate_phase_deadtime #(
            .DEADTIME_CYCLES(DEADTIME_CYCLES)
        ) u_phase (
            .sys_clk    (sys_clk),
            .reset_n    (reset_n),
            .force_off_i(force_off),
            .high_req_i (gate_high_side_in[i]),
            .low_req_i  (gate_low_side_in[i]),
            .high_o     (gate_high_side_out[i]),
            .low_o      (gate_low_side_out[i]),
            .shoot_err_o(shoot_through_err_out[i])
        );
    end

endmodule

// File: tb/tb_gate_driver_protect_unit.sv
// Directed bench for gate_driver_protect_unit with dead time 4, filter 3, 3 phases.
module tb_gate_driver_protect_unit;

    localparam int unsigned Phases = 3;

    logic              sys_clk;
    logic              reset_n;
    logic              nfault;
    logic              enable;
    logic              clear;
    logic [Phases-1:0] h_in, l_in;
    logic [Phases-1:0] h_out, l_out, err_out;
    logic              fault_out;

    int n_checks;
    int n_errors;
    int overlap_viol;

    gate_driver_protect_unit #(
        .PHASE_NUM          (Phases),
        .DEADTIME_CYCLES    (4),
        .FAULT_FILTER_CYCLES(3),
        .FAULT_LATCH        (1)
    ) dut (
        .sys_clk              (sys_clk),
        .reset_n              (reset_n),
        .gate_driver_nfault_in(nfault),
        .gate_enable_in       (enable),
        .fault_clear_in       (clear),
        .gate_high_side_in    (h_in),
        .gate_low_side_in     (l_in),
        .gate_high_side_out   (h_out),
        .gate_low_side_out    (l_out),
        .fault_latched_out    (fault_out),
        .shoot_through_err_out(err_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Overlap monitor on every falling edge
    always @(negedge sys_clk) begin
        if ((h_out & l_out) != '0) overlap_viol = overlap_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        overlap_viol = 0;
        reset_n = 1'b0;
        nfault  = 1'b1;
        enable  = 1'b1;
        clear   = 1'b0;
        h_in    = '0;
        l_in    = '0;
        ticks(3);
        check("rst_high", 32'(h_out), 0);
        check("rst_low", 32'(l_out), 0);
        check("rst_fault", 32'(fault_out), 0);
        check("rst_err", 32'(err_out), 0);
        reset_n = 1'b1;
        ticks(2);

        // Idle OFF -> HIGH in one edge
        h_in = 3'b001;
        tick();
        check("idle_to_high_h", 32'(h_out), 32'h1);
        check("idle_to_high_l", 32'(l_out), 0);

        // HIGH -> LOW: five off cycles then LOW
        h_in = 3'b000;
        l_in = 3'b001;
        tick();
        check("sw_first_off_h", 32'(h_out), 0);
        check("sw_first_off_l", 32'(l_out), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sw_dead_off", 32'(h_out | l_out), 0);
        end
        tick();
        check("sw_low_on", 32'(l_out), 32'h1);

        // Phase1 into LOW, then shoot-through request
        l_in = 3'b011;
        tick();
        check("ph1_low", 32'(l_out), 32'h3);
        h_in = 3'b010;
        tick();
        check("st_low", 32'(l_out), 32'h1);
        check("st_high", 32'(h_out), 0);
        check("st_err", 32'(err_out), 32'h2);
        h_in = 3'b000;
        l_in = 3'b001;
        tick();
        check("st_err_clear", 32'(err_out), 0);

        // Short nFAULT glitch is filtered
        nfault = 1'b0;
        ticks(2);
        nfault = 1'b1;
        ticks(6);
        check("glitch_fault", 32'(fault_out), 0);
        check("glitch_low", 32'(l_out), 32'h1);

        // Sustained fault: latch and force-off at edge 5 after the fall
        nfault = 1'b0;
        ticks(4);
        check("flt_edge4", 32'(fault_out), 0);
        check("flt_edge4_low", 32'(l_out), 32'h1);
        tick();
        check("flt_edge5", 32'(fault_out), 32'h1);
        check("flt_edge5_out", 32'(h_out | l_out), 0);

        // Clear while fault still present is ignored
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ignored", 32'(fault_out), 32'h1);
        nfault = 1'b1;
        ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_taken", 32'(fault_out), 0);
        check("clr_out_off", 32'(l_out), 0);
        ticks(4);
        check("clr_still_dead", 32'(h_out | l_out), 0);
        tick();
        check("clr_resume", 32'(l_out), 32'h1);

        // Phase2 HIGH, then one-cycle disable
        h_in = 3'b100;
        tick();
        check("ph2_high", 32'(h_out), 32'h4);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        check("dis_high", 32'(h_out), 0);
        check("dis_low", 32'(l_out), 0);
        ticks(4);
        check("dis_dead", 32'(h_out | l_out), 0);
        tick();
        check("reen_high", 32'(h_out), 32'h4);
        check("reen_low", 32'(l_out), 32'h1);

        // Asynchronous reset in the middle of a dead time
        h_in = 3'b000;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(h_out | l_out), 0);
        #2;
        reset_n = 1'b1;
        h_in = 3'b100;
        tick();
        check("post_rst_high", 32'(h_out), 32'h4);
        check("post_rst_low", 32'(l_out), 32'h1);

        check("overlap", 32'(overlap_viol), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_driver_protect_unit.md
Name: gate_driver_protect_unit

Overview:
- Parametrised, fault-protected gate-drive output stage for PHASE_NUM half-bridges. Sits between the PWM/commutation logic and the gate-driver IC pins.
- Adds the following per phase:
  - shoot-through rejection
  - programmable dead-time insertion
  - a glitch-filtered, latched nFAULT input with software clear
  - a global gate enable
- Every output is registered, so the pins are glitch-free.

Parameters:
- PHASE_NUM, 3: number of half-bridge phases; range 1..8.
- DEADTIME_CYCLES, 50: extra sys_clk cycles during which both switches stay off between high/low conduction; range 0..1023.
- FAULT_FILTER_CYCLES, 4: consecutive low samples of the synchronised nFAULT needed to declare a fault; range 1..255.
- FAULT_LATCH, 1: 1 = fault stays set until cleared; 0 = fault follows the filtered input.

Ports:
- sys_clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- gate_driver_nfault_in  input  1  gate-driver fault, active-low, asynchronous to sys_clk.
- gate_enable_in  input  1  global enable; 0 forces every phase off.
- fault_clear_in  input  1  single-cycle pulse that clears the latched fault.
- gate_high_side_in  input  PHASE_NUM  high-side requests; bit i = phase i.
- gate_low_side_in  input  PHASE_NUM  low-side requests.
- gate_high_side_out  output  PHASE_NUM  high-side gate pins.
- gate_low_side_out  output  PHASE_NUM  low-side gate pins.
- fault_latched_out  output  1  fault active (latched or live, per FAULT_LATCH).
- shoot_through_err_out  output  PHASE_NUM  one-cycle pulse per phase when high and low are requested together.

Behaviour:
- Reset values:
  - all outputs 0
  - every phase in OFF with its dead counter at 0
  - synchroniser flops at 1
  - filter counter at 0
- nFAULT synchronisation and filter:
  - nFAULT passes through a 2-flop synchroniser.
  - The filter counter increments while the synchronised value is 0 and returns to 0 when it is 1.
  - fault_det = counter reaches FAULT_FILTER_CYCLES; the counter saturates there.
  - Latency: fault_det asserts 2+FAULT_FILTER_CYCLES edges after nfault_in falls.
- Fault latch:
  - With FAULT_LATCH=1, fault_latched_out sets on the edge where fault_det is first true.
  - It clears on fault_clear_in only if fault_det=0 in that cycle. If fault_det is still 1, the clear is ignored and the fault stays set.
  - With FAULT_LATCH=0, fault_latched_out = fault_det, registered.
- Force-off condition: force_off = !gate_enable_in | fault_det | fault_latched_out.
  - On the edge where force_off is first seen, every phase goes to OFF with both outputs 0 and its dead counter reloaded. Outputs therefore drop on the same edge that the latch sets.
- Request decode, per phase:
  - H=1, L=0 gives REQ_HIGH.
  - H=0, L=1 gives REQ_LOW.
  - H=0, L=0 gives REQ_OFF.
  - H=1, L=1 gives REQ_OFF and pulses shoot_through_err_out[i] for one cycle; the pulse is registered.
- Phase FSM, with states OFF, HIGH and LOW:
  - HIGH: high=1, low=0. If the request is anything other than REQ_HIGH, or force_off=1, go to OFF and load dead_cnt=DEADTIME_CYCLES.
  - LOW: mirror of HIGH.
  - OFF: both outputs 0.
    - If dead_cnt!=0, decrement it and ignore the request.
    - If dead_cnt==0 and force_off=0, go to HIGH on REQ_HIGH or LOW on REQ_LOW; otherwise stay in OFF.
- Resulting timing:
  - A direct HIGH to LOW switch holds both outputs off for exactly DEADTIME_CYCLES+1 cycles.
  - With DEADTIME_CYCLES=0, the switch still passes through one off cycle.
  - From an idle OFF state with dead_cnt=0, the request-to-output latency is 1 edge.
- Invariant: high_out[i] & low_out[i] is never 1, in any cycle or in any reset state.
- Dead counter width: max(1, $clog2(DEADTIME_CYCLES+1)).
- Mid-operation events:
  - A reset_n assertion mid-operation immediately returns all outputs to 0, asynchronously.
  - When force_off deasserts, phases restart through OFF, so they honour the full dead time before conducting.

Decomposition:
- project_param.v holds:
  - the phase state encodings: OFF=2'd0, HIGH=2'd1, LOW=2'd2
  - the default DEADTIME_CYCLES and FAULT_FILTER_CYCLES values
- One sub-module, gate_phase_deadtime, holds the request decode, phase FSM, dead counter and output registers for a single phase. The top instantiates it PHASE_NUM times with a generate loop.
- The top owns the synchroniser, the filter and the fault latch.

Test Plan (DEADTIME_CYCLES=4, FAULT_FILTER_CYCLES=3, PHASE_NUM=3, enable=1 unless stated):
- Reset, then set phase0 H=1 at cycle t → high_out[0]=1 at edge t+1; all other outputs remain 0.
- Phase0 in HIGH, request switches to L=1 at cycle t → high_out[0]=0 at t+1; low_out[0]=1 at t+6; both outputs are 0 for exactly 5 cycles.
- Phase1 H=1 and L=1 together for 1 cycle while in LOW → both outputs go 0 next edge; shoot_through_err_out=3'b010 for one cycle; the overlap invariant holds throughout.
- nfault_in low for 2 cycles → no fault, outputs unchanged.
- nfault_in low for 6 cycles → fault_latched_out=1 and all outputs 0 at 5 edges after the fall.
- After that fault, fault_clear_in pulsed while nfault_in is still low → fault stays set. Release nfault_in and wait 2 cycles, then pulse the clear → fault_latched_out=0; outputs resume after 5 off cycles.
- gate_enable_in=0 for 1 cycle while phase2 is in HIGH → outputs go 0 next edge; on re-enable, high_out[2] returns after the 4-cycle dead count. A reset_n pulse mid-dead-time → all outputs 0 immediately; dead_cnt=0 after release.
